sp1_fifo: RTL and testbench
===========================

Name: sp1_fifo

Overview:
- Synchronous first-word-fall-through FIFO feeding the sp1_ff enabled register stage.
- Producer logic pushes DW-bit words. The consumer side connects as follows: pop is driven from !empty, rd_data goes to sp1_ff.d, and the pop strobe goes to sp1_ff.en.
- Decouples producer bursts from the one-word-per-cycle capture rate of sp1_ff.

Parameters:
DW, 32, data width in bits
DEPTH, 4, number of entries; must be a power of two, >= 2
AW, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
wr_en  input  1  push request
wr_data  input  DW  push data, sampled on the rising edge when the push is accepted
rd_en  input  1  pop request
rd_data  output  DW  head-of-queue word; valid whenever empty=0
empty  output  1  no entries stored
full  output  1  DEPTH entries stored
count  output  AW+1  number of stored entries, 0..DEPTH
ovf  output  1  one-cycle pulse: a push was rejected
udf  output  1  one-cycle pulse: a pop was rejected

Behaviour:
- Reset (asynchronous, active-high; rst high at any time including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, ovf=0, udf=0.
  - rd_data=0.
  - Storage array contents are not cleared and are never observable.
- Pointers: AW bits wide; increment modulo DEPTH, wrapping from DEPTH-1 to 0.
- count: AW+1 bits; never exceeds DEPTH, never below 0.
- empty is (count==0) and full is (count==DEPTH). Both are derived from registered count, with no combinational path from wr_en or rd_en.
- Push accepted when wr_en=1 and (full=0, or rd_en=1 with full=1). Effect at the edge: mem[wr_ptr] <= wr_data, then wr_ptr advances.
- Pop accepted when rd_en=1 and empty=0. Effect at the edge: rd_ptr advances.
- Count update at the edge: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
- Full with rd_en=1 and wr_en=1: both accepted, count stays DEPTH, full stays 1.
- Empty with rd_en=1 and wr_en=1:
  - Push accepted; pop rejected, and udf pulses for one cycle.
  - After the edge, count=1 and rd_data=the pushed word.
- Full with wr_en=1 and rd_en=0: push rejected, data dropped, ovf pulses for one cycle, state unchanged.
- Empty with rd_en=1 and wr_en=0: no state change, udf pulses for one cycle.
- rd_data is combinational from mem[rd_ptr] when empty=0, and forced to 0 when empty=1.
- Latency: a word pushed at edge N into an empty FIFO appears on rd_data with empty=0 immediately after edge N. There are no bubble cycles.
- ovf and udf are registered: high for exactly the one cycle following the offending edge, and low otherwise.
- X on wr_en or rd_en while rst=0 is a protocol error. A non-synthesis check prints "sp1_fifo: X on control" with $time.
- FIFO state after an X-control edge is not guaranteed; the bench re-applies rst to recover.
- X on wr_data during an accepted push is stored and passed through unchanged; no error.

Test Plan:
- Reset then idle: rst high for 5 cycles then low -> empty=1, full=0, count=0, rd_data=00000000, ovf=udf=0 throughout.
- Fill and drain:
  - Push ffffffff, 00000000, 12345678, cafecafe on consecutive cycles -> count 1,2,3,4, then full=1.
  - A 5th push of 33333333 -> ovf=1 for one cycle, count stays 4.
  - Pop 4 times -> rd_data sequence ffffffff, 00000000, 12345678, cafecafe, then empty=1 and rd_data=0.
- Wrap-around:
  - Push 3 words, pop 3, then push 33333333, cccccccc, 55555555, aaaaaaaa -> pointers wrap.
  - Pops return the same order; count returns to 0.
- Simultaneous push and pop:
  - At full, push beefbeef while popping -> count stays 4, head advances, beefbeef emerges 4th.
  - At empty, push plus pop -> udf=1, count=1, rd_data=beefbeef.
- Async reset mid-operation: with count=3, raise rst at the negedge plus 1 -> empty=1, count=0, rd_data=0 before the next posedge. The following push of 12345678 appears on rd_data.
- Downstream chain: connect to sp1_ff (en=pop strobe, d=rd_data), push cafecafe -> sp1_ff.q=cafecafe one cycle after the pop edge; q holds while the FIFO is empty.

Source files
------------

// File: rtl/sp1_fifo.sv
// sp1_fifo: first-word-fall-through FIFO with registered overflow/underflow pulses,
// feeding the sp1_ff enabled register stage.
module sp1_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, udf_q, push, pop;

    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);
    // A pop at full frees the slot in the same edge, so a simultaneous push is accepted.
    assign push  = wr_en && (!full || rd_en);
    assign pop   = rd_en && !empty;
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_d;
            ovf_q    <= wr_en && !push;
            udf_q    <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_q];
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && $isunknown({wr_en, rd_en})) $error("sp1_fifo: X on control at %0t", $time);
    end
`endif
endmodule

// File: tb/tb_sp1_fifo.sv
// tb_sp1_fifo: directed stimulus with a scoreboard queue; a negedge monitor checks every popped word.
module tb_sp1_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        empty, full, ovf, udf;
    logic [2:0]  count;
    logic [31:0] ff_q;
    logic [31:0] sb [$];
    int passed = 0;
    int total  = 0;

    sp1_fifo #(.DW(32), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Downstream sp1_ff stage: captures rd_data on the pop strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= '0;
        else if (rd_en && !empty) ff_q <= rd_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (sb.size() == 0) chk("pop_unexpected", rd_data, 32'hxxxxxxxx);
            else chk("pop_data", rd_data, sb.pop_front());
        end
    end

    task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic acc);
        wr_en = w; wr_data = d; rd_en = r;
        if (acc) sb.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] fill [4];
        logic [31:0] wrap [4];
        fill = '{32'hffffffff, 32'h00000000, 32'h12345678, 32'hcafecafe};
        wrap = '{32'h33333333, 32'hcccccccc, 32'h55555555, 32'haaaaaaaa};
        repeat (5) @(posedge clk);
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("idle_empty", {31'd0, empty}, 32'd1);
        chk("idle_full", {31'd0, full}, 32'd0);
        chk("idle_count", {29'd0, count}, 32'd0);
        chk("idle_rd_data", rd_data, 32'd0);
        chk("idle_ovf_udf", {30'd0, ovf, udf}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, fill[i], 0, 1);
            chk("fill_count", {29'd0, count}, 32'(i + 1));
            chk("fill_head", rd_data, 32'hffffffff);
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        cyc(1, 32'h33333333, 0, 0);
        chk("ovf_pulse", {31'd0, ovf}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        cyc(0, 0, 0, 0);
        chk("ovf_clear", {31'd0, ovf}, 32'd0);
        repeat (4) cyc(0, 0, 1, 0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_rd_data", rd_data, 32'd0);
        cyc(0, 0, 1, 0);
        chk("udf_pulse", {31'd0, udf}, 32'd1);
        chk("udf_count", {29'd0, count}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("udf_clear", {31'd0, udf}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h11111111 * (i + 1), 0, 1);
        repeat (3) cyc(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, wrap[i], 0, 1);
        chk("wrap_full", {31'd0, full}, 32'd1);
        cyc(1, 32'hbeefbeef, 1, 1);
        chk("rw_full_count", {29'd0, count}, 32'd4);
        chk("rw_full_flag", {31'd0, full}, 32'd1);
        chk("rw_full_head", rd_data, 32'hcccccccc);
        repeat (4) cyc(0, 0, 1, 0);
        chk("wrap_count", {29'd0, count}, 32'd0);
        cyc(1, 32'hbeefbeef, 1, 1);
        chk("rw_empty_udf", {31'd0, udf}, 32'd1);
        chk("rw_empty_count", {29'd0, count}, 32'd1);
        chk("rw_empty_data", rd_data, 32'hbeefbeef);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'ha0a0a0a0 + i, 0, 0);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_ff", ff_q, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 32'h12345678, 0, 1);
        chk("post_rst_data", rd_data, 32'h12345678);
        cyc(0, 0, 1, 0);
        cyc(1, 32'hcafecafe, 0, 1);
        cyc(0, 0, 1, 0);
        chk("chain_q", ff_q, 32'hcafecafe);
        repeat (2) cyc(0, 0, 1, 0);
        chk("chain_hold", ff_q, 32'hcafecafe);
        chk("chain_empty", {31'd0, empty}, 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
